logical_mc: RTL and testbench



---
 rtl/logical_pkg.sv | 25 ++
 rtl/logical_chunk_cnt.sv | 35 +++
 rtl/logical_mc.sv | 118 +++++++++++
 tb/tb_logical_mc.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/logical_pkg.sv
// Shared types for the multi-cycle logical unit: operation and FSM encodings.
package logical_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NOR    = 3'b011,
    OP_CLZ    = 3'b100,
    OP_CLO    = 3'b101,
    OP_POPCNT = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_count_op(input op_e o);
    return (o == OP_CLZ) || (o == OP_CLO) || (o == OP_POPCNT);
  endfunction

endpackage

// File: rtl/logical_chunk_cnt.sv
// Combinational per-chunk counter: leading zeros, nonzero flag and popcount.
module logical_chunk_cnt #(
  parameter int CHUNK = 4,
  localparam int CCW = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             mode,
  output logic [CCW-1:0]   lead_zero,
  output logic             nonzero,
  output logic [CCW-1:0]   popcount
);

  logic [CCW-1:0] lz;
  logic [CCW-1:0] pc;
  logic           hit;

  // mode=1 selects popcount; the unused count is forced to zero
  always_comb begin
    lz  = '0;
    pc  = '0;
    hit = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        hit = 1'b1;
        pc  = pc + CCW'(1);
      end else if (!hit) begin
        lz = lz + CCW'(1);
      end
    end
    lead_zero = mode ? '0 : lz;
    popcount  = mode ? pc : '0;
    nonzero   = |chunk;
  end

endmodule

// File: rtl/logical_mc.sv
// Multi-cycle logical unit: single-cycle bitwise ops, chunk-iterative CLZ/CLO/POPCNT.
module logical_mc
  import logical_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] R
);

  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(N + 1);
  localparam int CCW = $clog2(CHUNK + 1);

  if ((N % CHUNK) != 0 || N < 4) begin : g_bad_param
    $error("logical_mc: N must be >= 4 and a multiple of CHUNK");
  end

  state_e                     state, state_nxt;
  op_e                        op_in, op_q;
  logic [N-1:0]               a_q, r_q, bw_res;
  logic [NCH-1:0][CHUNK-1:0]  chunks;
  logic [CHUNK-1:0]           cur;
  logic [IW-1:0]              idx;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic                       found, nz, accept;
  logic [CCW-1:0]             lz, pc;

  assign op_in     = op_e'(op);
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign R         = r_q;
  assign accept    = in_valid && in_ready;

  assign chunks = a_q;
  assign cur    = chunks[idx];

  logical_chunk_cnt #(.CHUNK(CHUNK)) u_chunk_cnt (
    .chunk     (cur),
    .mode      (op_q == OP_POPCNT),
    .lead_zero (lz),
    .nonzero   (nz),
    .popcount  (pc)
  );

  always_comb begin
    case (op_in)
      OP_AND:  bw_res = A & B;
      OP_OR:   bw_res = A | B;
      OP_XOR:  bw_res = A ^ B;
      OP_NOR:  bw_res = ~(A | B);
      default: bw_res = '1;
    endcase
  end

  // Leading counts stop accumulating once a chunk with a set bit has been seen
  always_comb begin
    cnt_nxt = cnt;
    if (op_q == OP_POPCNT) cnt_nxt = cnt + CW'(pc);
    else if (!found)       cnt_nxt = cnt + CW'(lz);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_count_op(op_in) ? BUSY : DONE;
      BUSY: if (idx == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      idx   <= '0;
      cnt   <= '0;
      found <= 1'b0;
    end else if (accept) begin
      if (is_count_op(op_in)) begin
        idx   <= IW'(NCH - 1);
        cnt   <= '0;
        found <= 1'b0;
      end else begin
        r_q <= bw_res;
      end
    end else if (state == BUSY) begin
      cnt   <= cnt_nxt;
      found <= found | nz;
      idx   <= idx - IW'(1);
      if (idx == '0) r_q <= N'(cnt_nxt);
    end
  end

  // CLO is scanned as CLZ of the inverted operand
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= (op_in == OP_CLO) ? ~A : A;
      op_q <= op_in;
    end
  end

endmodule

// File: tb/tb_logical_mc.sv
// Randomized self-checking bench for logical_mc against a bit-level reference model.
module tb_logical_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B, R;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  logical_mc #(.N(32), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lead_zeros(input logic [31:0] v);
    int n = 0;
    while (n < 32 && v[31 - n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return 32'(lead_zeros(a));
      3'd5: return 32'(lead_zeros(~a));
      3'd6: return 32'($countones(a));
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat, want_lat;
    exp      = ref_res(o, a, b);
    want_lat = (o >= 3'd4 && o <= 3'd6) ? 9 : 1;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; A = a; B = b; out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      check("busy_ready", 32'(in_ready), 32'd0);
      A = $urandom; B = $urandom; op = 3'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("latency", 32'(lat), 32'(want_lat));
    check("result", R, exp);
    for (int h = 0; h < hold; h++) begin
      A = $urandom; op = 3'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", R, exp);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] pend, ra, rb;
    logic        last;
    logic [2:0]  ro;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", R, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(in_ready), 32'd1);

    run_op(3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    check("and_vec", ref_res(3'd0, 32'hF0F0_1234, 32'h0FF0_FF00), 32'h00F0_1200);
    run_op(3'd3, 32'h0000_0000, 32'h0000_FFFF, 1);
    run_op(3'd4, 32'h0001_0000, 32'h0, 0);
    run_op(3'd4, 32'h0000_0000, 32'h0, 0);
    run_op(3'd4, 32'h8000_0000, 32'h0, 0);
    run_op(3'd5, 32'hFFFF_FFF0, 32'h0, 2);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h0, 0);
    run_op(3'd6, 32'hF0F0_0001, 32'h0, 0);
    run_op(3'd6, 32'hFFFF_FFFF, 32'h0, 5);
    run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Back-to-back: in_valid held high, accepts only in IDLE cycles
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd2;
    last = in_ready;
    pend = '0;
    for (int i = 0; i < 16; i++) begin
      A = $urandom; B = $urandom;
      if (last) pend = A ^ B;
      @(negedge clk);
      check("b2b_ready", 32'(in_ready), 32'(!last));
      check("b2b_valid", 32'(out_valid), 32'(last));
      if (last) check("b2b_result", R, pend);
      last = in_ready;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;

    // Reset in the 4th BUSY cycle of a CLZ
    in_valid = 1'b1; op = 3'd4; A = 32'h0001_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_result", R, 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    run_op(3'd0, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 32'h0;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'h1 << $urandom_range(0, 31);
        default: ra = $urandom;
      endcase
      rb = $urandom;
      run_op(ro, ra, rb, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
